// File: rtl/main_mem_pkg.sv
// Shared types and helpers for the main-memory responder model.
package main_mem_pkg;

  localparam int unsigned ADDR_WIDTH  = 32;
  localparam int unsigned WORD_WIDTH  = 32;
  localparam int unsigned BLOCK_WIDTH = 64;
  localparam int unsigned WORD_BYTES  = WORD_WIDTH / 8;
  localparam int unsigned BLOCK_BYTES = BLOCK_WIDTH / 8;

  localparam logic [2:0] SIZE_NONE = 3'b000;
  localparam logic [2:0] SIZE_BYTE = 3'b001;
  localparam logic [2:0] SIZE_HALF = 3'b010;
  localparam logic [2:0] SIZE_WORD = 3'b100;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  typedef struct packed {
    logic                  ifu;
    logic [ADDR_WIDTH-1:0] addr;
    logic [2:0]            size;
  } req_t;

  typedef struct packed {
    logic                   valid;
    logic                   lsu_aL_ifu_aH;
    logic [ADDR_WIDTH-1:0]  addr;
    logic [2:0]             size;
    logic [BLOCK_WIDTH-1:0] data;
  } resp_t;

  // Non-one-hot sizes resolve Word > Half > Byte; zero size moves no bytes.
  function automatic logic [3:0] size_bytes(input logic [2:0] size);
    if ((size & SIZE_WORD) != 3'b000) return 4'd4;
    if ((size & SIZE_HALF) != 3'b000) return 4'd2;
    if ((size & SIZE_BYTE) != 3'b000) return 4'd1;
    return 4'd0;
  endfunction

endpackage

// File: rtl/main_mem_array.sv
// Byte-addressed backing store: one byte-enabled store port and one wrapping
// 8-byte read port that forwards a store landing in the same cycle.
module main_mem_array
  import main_mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 4096,
  parameter int unsigned AW        = $clog2(MEM_BYTES)
) (
  input  logic                   clk,
  input  logic                   st_en,
  input  logic [AW-1:0]          st_addr,
  input  logic [2:0]             st_size,
  input  logic [WORD_WIDTH-1:0]  st_data,
  input  logic [AW-1:0]          rd_addr,
  output logic [BLOCK_WIDTH-1:0] rd_data
);

  logic [7:0]    mem [MEM_BYTES];
  logic [3:0]    st_n;
  logic [AW-1:0] off [BLOCK_BYTES];

  assign st_n = size_bytes(st_size);

  // Little-endian byte writes; index arithmetic wraps at the top of the array.
  always_ff @(posedge clk) begin
    if (st_en) begin
      for (int i = 0; i < int'(WORD_BYTES); i++) begin
        if (4'(i) < st_n) mem[st_addr + AW'(i)] <= st_data[8*i +: 8];
      end
    end
  end

  // A byte is forwarded when its distance above st_addr falls inside the store.
  always_comb begin
    rd_data = '0;
    off     = '{default: '0};
    for (int j = 0; j < int'(BLOCK_BYTES); j++) begin
      off[j] = rd_addr + AW'(j) - st_addr;
      rd_data[8*j +: 8] = mem[rd_addr + AW'(j)];
      if (st_en && (off[j] < AW'(st_n))) rd_data[8*j +: 8] = st_data[8*off[j][1:0] +: 8];
    end
  end

endmodule

// File: rtl/main_mem_ctrl.sv
// Main-memory responder: arbitrates IFU fills and LSU loads, answers each after
// a fixed latency, and absorbs core stores into the backing array.
module main_mem_ctrl
  import main_mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 4096,
  parameter int unsigned LATENCY   = 4
) (
  input  logic                   clk,
  input  logic                   rst_aL,
  input  logic                   ifu_req_valid,
  output logic                   ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0]  ifu_req_addr,
  input  logic                   lsu_req_valid,
  output logic                   lsu_req_ready,
  input  logic [ADDR_WIDTH-1:0]  lsu_req_addr,
  input  logic [2:0]             lsu_req_size,
  input  logic                   st_en,
  input  logic [ADDR_WIDTH-1:0]  st_addr,
  input  logic [2:0]             st_size,
  input  logic [WORD_WIDTH-1:0]  st_data,
  output logic                   recv_main_mem_valid,
  output logic                   recv_main_mem_lsu_aL_ifu_aH,
  output logic [ADDR_WIDTH-1:0]  recv_main_mem_addr,
  output logic [2:0]             recv_size_main_mem,
  output logic [BLOCK_WIDTH-1:0] recv_main_mem_data
);

  localparam int unsigned AW = $clog2(MEM_BYTES);
  localparam int unsigned CW = $clog2(LATENCY + 1);

  state_e                 state;
  logic [CW-1:0]          cnt;
  logic                   prio_ifu;
  req_t                   req_q;
  req_t                   req_cur;
  resp_t                  resp_q;
  resp_t                  resp_next;
  logic                   contested;
  logic                   grant_ifu;
  logic                   grant_lsu;
  logic [AW-1:0]          rd_addr;
  logic [BLOCK_WIDTH-1:0] rd_data;
  logic [3:0]             ld_n;
  logic                   unused_st_addr;

  assign unused_st_addr = ^st_addr[ADDR_WIDTH-1:AW];

  // Only the winner of a contested cycle sees ready; nobody does during reset.
  assign contested     = ifu_req_valid && lsu_req_valid;
  assign ifu_req_ready = rst_aL && (state == ST_IDLE) && !(contested && !prio_ifu);
  assign lsu_req_ready = rst_aL && (state == ST_IDLE) && !(contested && prio_ifu);
  assign grant_ifu     = ifu_req_valid && ifu_req_ready;
  assign grant_lsu     = lsu_req_valid && lsu_req_ready;

  // In IDLE the live granted request is used so a one-cycle latency still works.
  always_comb begin
    req_cur = req_q;
    if (state == ST_IDLE) begin
      req_cur.ifu  = grant_ifu;
      req_cur.addr = grant_ifu ? ifu_req_addr : lsu_req_addr;
      req_cur.size = grant_ifu ? SIZE_NONE : lsu_req_size;
    end
  end

  assign rd_addr = req_cur.ifu ? {req_cur.addr[AW-1:3], 3'b000} : req_cur.addr[AW-1:0];
  assign ld_n    = size_bytes(req_cur.size);

  main_mem_array #(
    .MEM_BYTES (MEM_BYTES),
    .AW        (AW)
  ) u_array (
    .clk     (clk),
    .st_en   (st_en),
    .st_addr (st_addr[AW-1:0]),
    .st_size (st_size),
    .st_data (st_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // LSU data keeps only the requested low bytes; IFU returns the full block.
  always_comb begin
    resp_next               = '0;
    resp_next.valid         = 1'b1;
    resp_next.lsu_aL_ifu_aH = req_cur.ifu;
    resp_next.addr          = req_cur.ifu ? {req_cur.addr[ADDR_WIDTH-1:3], 3'b000} : req_cur.addr;
    resp_next.size          = req_cur.size;
    for (int j = 0; j < int'(BLOCK_BYTES); j++) begin
      if (req_cur.ifu || (4'(j) < ld_n)) resp_next.data[8*j +: 8] = rd_data[8*j +: 8];
    end
  end

  // Response register loads on the edge into RESP and clears on every other edge.
  always_ff @(posedge clk) begin
    if (!rst_aL) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      prio_ifu <= 1'b0;
      req_q    <= '0;
      resp_q   <= '0;
    end else begin
      resp_q <= '0;
      case (state)
        ST_IDLE: begin
          if (grant_ifu || grant_lsu) begin
            req_q <= req_cur;
            if (contested) prio_ifu <= grant_lsu;
            if (LATENCY <= 1) begin
              state  <= ST_RESP;
              resp_q <= resp_next;
            end else begin
              state <= ST_WAIT;
              cnt   <= CW'(LATENCY - 1);
            end
          end
        end
        ST_WAIT: begin
          if (cnt <= CW'(1)) begin
            state  <= ST_RESP;
            cnt    <= '0;
            resp_q <= resp_next;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign recv_main_mem_valid         = resp_q.valid;
  assign recv_main_mem_lsu_aL_ifu_aH = resp_q.lsu_aL_ifu_aH;
  assign recv_main_mem_addr          = resp_q.addr;
  assign recv_size_main_mem          = resp_q.size;
  assign recv_main_mem_data          = resp_q.data;

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Directed bench for main_mem_ctrl: arbitration, latency, store ordering, reset, wrap.
module tb_main_mem_ctrl;
  import main_mem_pkg::*;

  localparam int unsigned LAT = 4;

  logic        clk = 1'b0;
  logic        rst_aL;
  logic        ifu_req_valid, ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        lsu_req_valid, lsu_req_ready;
  logic [31:0] lsu_req_addr;
  logic [2:0]  lsu_req_size;
  logic        st_en;
  logic [31:0] st_addr;
  logic [2:0]  st_size;
  logic [31:0] st_data;
  logic        recv_main_mem_valid, recv_main_mem_lsu_aL_ifu_aH;
  logic [31:0] recv_main_mem_addr;
  logic [2:0]  recv_size_main_mem;
  logic [63:0] recv_main_mem_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  main_mem_ctrl #(.MEM_BYTES(4096), .LATENCY(LAT)) dut (
    .clk                         (clk),
    .rst_aL                      (rst_aL),
    .ifu_req_valid               (ifu_req_valid),
    .ifu_req_ready               (ifu_req_ready),
    .ifu_req_addr                (ifu_req_addr),
    .lsu_req_valid               (lsu_req_valid),
    .lsu_req_ready               (lsu_req_ready),
    .lsu_req_addr                (lsu_req_addr),
    .lsu_req_size                (lsu_req_size),
    .st_en                       (st_en),
    .st_addr                     (st_addr),
    .st_size                     (st_size),
    .st_data                     (st_data),
    .recv_main_mem_valid         (recv_main_mem_valid),
    .recv_main_mem_lsu_aL_ifu_aH (recv_main_mem_lsu_aL_ifu_aH),
    .recv_main_mem_addr          (recv_main_mem_addr),
    .recv_size_main_mem          (recv_size_main_mem),
    .recv_main_mem_data          (recv_main_mem_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    st_en = 1'b1; st_addr = a; st_size = s; st_data = d;
    tick();
    st_en = 1'b0;
  endtask

  // Idle-cycle handshake: readies as expected, response outputs quiet.
  task automatic accept(input string tag, input logic ei, input logic el);
    @(negedge clk);
    chk({tag, "_ifu_rdy"}, 64'(ifu_req_ready), 64'(ei));
    chk({tag, "_lsu_rdy"}, 64'(lsu_req_ready), 64'(el));
    chk({tag, "_idle_valid"}, 64'(recv_main_mem_valid), 64'd0);
    chk({tag, "_idle_data"}, recv_main_mem_data, 64'd0);
    tick();
  endtask

  task automatic resp(input string tag, input logic flag, input logic [31:0] a,
                      input logic [2:0] s, input logic [63:0] d);
    for (int k = 1; k < int'(LAT); k++) begin
      @(negedge clk);
      chk({tag, "_wait_valid"}, 64'(recv_main_mem_valid), 64'd0);
      chk({tag, "_wait_rdy"}, 64'({ifu_req_ready, lsu_req_ready}), 64'd0);
      tick();
    end
    @(negedge clk);
    chk({tag, "_valid"}, 64'(recv_main_mem_valid), 64'd1);
    chk({tag, "_flag"}, 64'(recv_main_mem_lsu_aL_ifu_aH), 64'(flag));
    chk({tag, "_addr"}, 64'(recv_main_mem_addr), 64'(a));
    chk({tag, "_size"}, 64'(recv_size_main_mem), 64'(s));
    chk({tag, "_data"}, recv_main_mem_data, d);
    tick();
  endtask

  task automatic lsu_load(input string tag, input logic [31:0] a, input logic [2:0] s,
                          input logic [63:0] d);
    lsu_req_valid = 1'b1; lsu_req_addr = a; lsu_req_size = s;
    accept(tag, 1'b1, 1'b1);
    lsu_req_valid = 1'b0;
    resp(tag, 1'b0, a, s, d);
  endtask

  initial begin
    rst_aL = 1'b0;
    ifu_req_valid = 1'b0; ifu_req_addr = '0;
    lsu_req_valid = 1'b0; lsu_req_addr = '0; lsu_req_size = '0;
    st_en = 1'b0; st_addr = '0; st_size = '0; st_data = '0;
    tick(); tick();
    @(negedge clk);
    chk("rst_rdy", 64'({ifu_req_ready, lsu_req_ready}), 64'd0);
    chk("rst_valid", 64'(recv_main_mem_valid), 64'd0);
    chk("rst_data", recv_main_mem_data, 64'd0);
    tick();
    rst_aL = 1'b1;
    @(negedge clk);
    chk("rel_rdy", 64'({ifu_req_ready, lsu_req_ready}), 64'd3);
    tick();

    // Preload through the store port, including a wrapping word and a null-size store.
    store(32'h100, SIZE_WORD, 32'h0403_0201);
    store(32'h104, SIZE_WORD, 32'h0807_0605);
    store(32'h200, SIZE_WORD, 32'h0000_0000);
    store(32'hFFE, SIZE_WORD, 32'hDDCC_BBAA);
    store(32'h100, SIZE_NONE, 32'hFFFF_FFFF);

    // IFU fill from mid-block address.
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h104;
    accept("t1", 1'b1, 1'b1);
    ifu_req_valid = 1'b0;
    resp("t1", 1'b1, 32'h100, 3'b000, 64'h0807_0605_0403_0201);

    // LSU sizes, including illegal encodings.
    lsu_load("t2h", 32'h102, SIZE_HALF, 64'h0403);
    lsu_load("t2b", 32'h107, SIZE_BYTE, 64'h08);
    lsu_load("t2z", 32'h100, 3'b000, 64'h0);
    lsu_load("t2m", 32'h100, 3'b110, 64'h0403_0201);
    lsu_load("t2n", 32'h100, SIZE_BYTE, 64'h01);

    // Contention: LSU wins from reset, then priority alternates.
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h100;
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h100; lsu_req_size = SIZE_WORD;
    accept("t3a", 1'b0, 1'b1);
    lsu_req_valid = 1'b0;
    resp("t3a", 1'b0, 32'h100, SIZE_WORD, 64'h0403_0201);
    accept("t3b", 1'b1, 1'b1);
    ifu_req_valid = 1'b0;
    resp("t3b", 1'b1, 32'h100, 3'b000, 64'h0807_0605_0403_0201);
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h100;
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h101; lsu_req_size = SIZE_BYTE;
    accept("t3c", 1'b1, 1'b0);
    ifu_req_valid = 1'b0;
    resp("t3c", 1'b1, 32'h100, 3'b000, 64'h0807_0605_0403_0201);
    accept("t3d", 1'b1, 1'b1);
    lsu_req_valid = 1'b0;
    resp("t3d", 1'b0, 32'h101, SIZE_BYTE, 64'h02);

    // Store in the last wait cycle is seen; store in the response cycle is not.
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h200; lsu_req_size = SIZE_WORD;
    accept("t4", 1'b1, 1'b1);
    lsu_req_valid = 1'b0;
    tick(); tick();
    st_en = 1'b1; st_addr = 32'h200; st_size = SIZE_WORD; st_data = 32'hDEAD_BEEF;
    tick();
    st_addr = 32'h200; st_size = SIZE_BYTE; st_data = 32'h0000_0011;
    @(negedge clk);
    chk("t4_valid", 64'(recv_main_mem_valid), 64'd1);
    chk("t4_data", recv_main_mem_data, 64'hDEAD_BEEF);
    tick();
    st_en = 1'b0;
    lsu_load("t4b", 32'h200, SIZE_WORD, 64'hDEAD_BE11);

    // Reset mid-wait drops the request.
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h104;
    accept("t5", 1'b1, 1'b1);
    ifu_req_valid = 1'b0;
    tick();
    rst_aL = 1'b0;
    @(negedge clk);
    chk("t5_rst_rdy", 64'({ifu_req_ready, lsu_req_ready}), 64'd0);
    chk("t5_rst_valid", 64'(recv_main_mem_valid), 64'd0);
    tick();
    rst_aL = 1'b1;
    @(negedge clk);
    chk("t5_rel_rdy", 64'({ifu_req_ready, lsu_req_ready}), 64'd3);
    chk("t5_rel_data", recv_main_mem_data, 64'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      @(negedge clk);
      chk("t5_no_valid", 64'(recv_main_mem_valid), 64'd0);
    end
    tick();
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h104;
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h107; lsu_req_size = SIZE_BYTE;
    accept("t5b", 1'b0, 1'b1);
    lsu_req_valid = 1'b0;
    resp("t5b", 1'b0, 32'h107, SIZE_BYTE, 64'h08);
    accept("t5c", 1'b1, 1'b1);
    ifu_req_valid = 1'b0;
    resp("t5c", 1'b1, 32'h100, 3'b000, 64'h0807_0605_0403_0201);

    // Multi-byte load wrapping past the top of the array.
    lsu_load("t6", 32'hFFE, SIZE_WORD, 64'hDDCC_BBAA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/main_mem_ctrl.md
Name: main_mem_ctrl

Overview:
- Main-memory responder at the far end of the core's memory interface; produces the recv_main_mem_* response stream the core consumes for I-cache fills (IFU) and loads (LSU).
- Accepts IFU block-read and LSU load requests, arbitrates between them, and returns one response after a fixed latency.
- Absorbs the core's store-write port (send_en_main_mem side) into a byte-addressable backing array.
- Used as the memory model in core-level simulation.

Parameters:
ADDR_WIDTH, 32, byte address width
WORD_WIDTH, 32, store/load word width
BLOCK_WIDTH, 64, I-cache fill block width (8 bytes)
MEM_BYTES, 4096, backing array size in bytes, power of 2
LATENCY, 4, cycles from request acceptance to response valid, >=1

Ports:
clk  in  1  clock
rst_aL  in  1  synchronous active-low reset
ifu_req_valid  in  1  IFU fill request
ifu_req_ready  out  1  IFU request accepted this cycle when high with valid
ifu_req_addr  in  ADDR_WIDTH  fill address, any byte in block
lsu_req_valid  in  1  LSU load request
lsu_req_ready  out  1  LSU request accepted this cycle when high with valid
lsu_req_addr  in  ADDR_WIDTH  load byte address
lsu_req_size  in  3  one-hot {Word,Halfword,Byte}
st_en  in  1  store write enable (from core send_en_main_mem)
st_addr  in  ADDR_WIDTH  store byte address
st_size  in  3  one-hot {Word,Halfword,Byte}
st_data  in  WORD_WIDTH  store data, low bytes used
recv_main_mem_valid  out  1  response valid, one cycle
recv_main_mem_lsu_aL_ifu_aH  out  1  0 = LSU response, 1 = IFU response
recv_main_mem_addr  out  ADDR_WIDTH  IFU: block-aligned address; LSU: request address
recv_size_main_mem  out  3  LSU: request size; IFU: 3'b000
recv_main_mem_data  out  BLOCK_WIDTH  response data, little-endian, zero-extended

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_aL).
- FSM states:
  - IDLE: both readies high. On grant, latch source/addr/size; go to WAIT with counter = LATENCY-1.
  - WAIT: counter decrements each cycle. At 0 (or immediately if LATENCY==1), go to RESP.
  - RESP: recv_main_mem_valid=1 for exactly one cycle, then IDLE.
- Request accepted in cycle t -> valid high in cycle t+LATENCY. Readies are low outside IDLE, so throughput is one request per LATENCY+1 cycles.
- Arbitration:
  - Only one source requesting: that source is granted.
  - Both requesting: grant the holder of the priority bit; priority flips to the loser after each contested grant.
  - Reset priority = LSU.
  - Only the granted source sees ready high; the other's ready is low that cycle.
- Requesters hold valid/addr/size stable until ready; the controller samples only in the grant cycle.
- Read data:
  - IFU: 8 bytes from addr & ~7.
  - LSU: 1/2/4 bytes from addr upward in low bits, upper bits 0. Misaligned accesses are allowed; sign extension is the LSU's job.
  - All array indexing is addr mod MEM_BYTES, so multi-byte accesses wrap past the top.
- Illegal sizes:
  - Non-one-hot size: priority Word>Half>Byte.
  - 3'b000 on an LSU load: zero data.
  - 3'b000 on a store: no write.
- Stores:
  - Always accepted, any state, no backpressure, one per cycle.
  - Byte writes are little-endian at the clock edge ending the st_en cycle.
- Store/read ordering:
  - A response reflects every store with st_en high in any cycle up to and including the last WAIT cycle (the cycle before RESP).
  - Stores in the RESP cycle are not reflected. Overlapping bytes merge byte-wise.
- Outputs during non-RESP cycles: valid=0; data/addr/size/flag hold 0.
- Reset (any cycle, including mid-WAIT or RESP):
  - State -> IDLE, counter 0, priority LSU; in-flight request dropped with no response.
  - All response outputs 0.
  - Readies high in the first cycle after rst_aL returns high; readies are 0 while rst_aL=0.
  - Array contents are not reset; they are loaded by testbench backdoor/$readmemh.

Decomposition:
- Package main_mem_pkg:
  - SIZE_BYTE/HALF/WORD one-hot constants
  - state enum {IDLE, WAIT, RESP}
  - packed resp_t {valid, lsu_aL_ifu_aH, addr, size, data}
  - size-to-byte-count function
- Sub-module main_mem_array:
  - byte-addressed storage, one store port with byte enables
  - one 8-byte wrapping read port with same-cycle store-merge forwarding
- main_mem_ctrl holds the FSM, arbiter, and response register.

Test Plan:
1. Backdoor mem[0x100..0x107]=01..08; IFU req 0x104 at cycle 0 -> readies low cycles 1-4; valid cycle 4, flag=1, addr=0x100, size=000, data=0x0807060504030201.
2. LSU half load 0x102 -> cycle 4: flag=0, addr=0x102, size=010, data=0x0403. Byte load 0x107 -> data=0x08.
3. IFU 0x100 and LSU word 0x100 both valid cycle 0 -> LSU response cycle 4, IFU accepted cycle 5, response cycle 9. Both valid again at cycle 10 -> IFU granted first.
4. Stores during an LSU word load of 0x200:
   - st word 0xDEADBEEF @0x200 in last WAIT cycle -> response data 0xDEADBEEF.
   - st byte 0x11 @0x200 in RESP cycle -> not reflected; next load returns 0xDEADBE11.
5. rst_aL=0 in cycle 2 of a pending IFU request -> no valid ever; outputs 0; readies high the cycle after release; next LSU request responds after LATENCY cycles.
6. Backdoor mem[0xFFE]=AA, [0xFFF]=BB, [0x000]=CC, [0x001]=DD; LSU word load 0xFFE (MEM_BYTES=4096) -> data=0xDDCCBBAA.
